// File: rtl/wb_pipe_stage_pkg.sv
// Shared definitions for the MEM->WB pipeline register: occupancy state encodings
// and the NOP-write constants used for bubbles and x0 suppression.
package wb_pipe_stage_pkg;

  typedef enum logic [1:0] {
    WB_ST_EMPTY = 2'b00,
    WB_ST_ONE   = 2'b01,
    WB_ST_TWO   = 2'b10
  } wb_state_e;

  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // Writes to the hard-wired zero register are turned into NOPs.
  function automatic logic gate_x0_wreg(input logic addr_is_zero, input logic wreg);
    return addr_is_zero ? WRITE_DISABLE : wreg;
  endfunction

endpackage

// File: rtl/wb_pipe_stage_skid_entry.sv
// One held register-file write request {wd, wreg, wdata} with load enable and
// synchronous clear; clear wins over load.
module wb_skid_entry #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] d_wd,
  input  logic              d_wreg,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] q_wd,
  output logic              q_wreg,
  output logic [DATA_W-1:0] q_wdata
);

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (clr) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
    end else if (load) begin
      wd_d    = d_wd;
      wreg_d  = d_wreg;
      wdata_d = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign q_wd    = wd_q;
  assign q_wreg  = wreg_q;
  assign q_wdata = wdata_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define WB_BYPASS_EN to drive the byp_* forwarding outputs; otherwise they read 0.
//
// state       | meaning
// WB_ST_EMPTY | nothing held, outputs are a NOP bubble
// WB_ST_ONE   | main entry valid on out_*
// WB_ST_TWO   | main valid plus one younger entry in the skid; in_ready low
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int STALL_W   = 5,
  parameter int STALL_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stalled,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic               in_wreg,
  input  logic [DATA_W-1:0]  in_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_wd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_wdata,
  output logic               byp_wreg,
  output logic [ADDR_W-1:0]  byp_wd,
  output logic [DATA_W-1:0]  byp_wdata
);

  wb_state_e state_q, state_d;
  logic      in_ready_q, in_ready_d;
  logic      advance, accept;
  logic      main_load, skid_load, main_from_skid;
  logic      in_wreg_g;

  logic [ADDR_W-1:0] main_d_wd, main_wd, skid_wd;
  logic              main_d_wreg, main_wreg, skid_wreg;
  logic [DATA_W-1:0] main_d_wdata, main_wdata, skid_wdata;

  // Only the STALL_IDX bit matters here; the rest of the vector belongs to other stages.
  logic unused_stall;
  assign unused_stall = ^stalled;

  assign out_valid = (state_q != WB_ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign advance   = out_valid & out_ready & ~stalled[STALL_IDX];
  assign accept    = in_valid & in_ready_q;
  assign in_wreg_g = gate_x0_wreg(in_wd == '0, in_wreg);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      WB_ST_EMPTY: begin
        if (accept) begin
          state_d   = WB_ST_ONE;
          main_load = 1'b1;
        end
      end
      WB_ST_ONE: begin
        if (accept && advance) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = WB_ST_TWO;
          skid_load = 1'b1;
        end else if (advance) begin
          state_d = WB_ST_EMPTY;
        end
      end
      WB_ST_TWO: begin
        if (advance) begin
          state_d        = WB_ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = WB_ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = WB_ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
    // Registered ready: looks at the next occupancy, never at out_ready this cycle.
    in_ready_d = (state_d != WB_ST_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WB_ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d_wd    = main_from_skid ? skid_wd    : in_wd;
  assign main_d_wreg  = main_from_skid ? skid_wreg  : in_wreg_g;
  assign main_d_wdata = main_from_skid ? skid_wdata : in_wdata;

  wb_skid_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .load    (main_load),
    .d_wd    (main_d_wd),
    .d_wreg  (main_d_wreg),
    .d_wdata (main_d_wdata),
    .q_wd    (main_wd),
    .q_wreg  (main_wreg),
    .q_wdata (main_wdata)
  );

  wb_skid_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .load    (skid_load),
    .d_wd    (in_wd),
    .d_wreg  (in_wreg_g),
    .d_wdata (in_wdata),
    .q_wd    (skid_wd),
    .q_wreg  (skid_wreg),
    .q_wdata (skid_wdata)
  );

  // The main register keeps stale contents after draining, so bubbles are masked here.
  assign out_wd    = out_valid ? main_wd    : '0;
  assign out_wreg  = out_valid ? main_wreg  : WRITE_DISABLE;
  assign out_wdata = out_valid ? main_wdata : '0;

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_wreg  = WRITE_DISABLE;
    byp_wd    = '0;
    byp_wdata = '0;
    if (state_q == WB_ST_TWO) begin
      byp_wreg  = skid_wreg;
      byp_wd    = skid_wd;
      byp_wdata = skid_wdata;
    end else if (state_q == WB_ST_ONE) begin
      byp_wreg  = main_wreg;
      byp_wd    = main_wd;
      byp_wdata = main_wdata;
    end
  end
`else
  assign byp_wreg  = WRITE_DISABLE;
  assign byp_wd    = '0;
  assign byp_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: a FIFO-queue model checked every cycle,
// plus directed scenarios with literal expectations (reset, stream, backpressure, stall, flush, x0).
module tb_wb_pipe_stage;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  stalled = 5'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_wd = 5'b0;
  logic        in_wreg = 1'b0;
  logic [31:0] in_wdata = 32'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_wreg, byp_wreg;
  logic [4:0]  out_wd, byp_wd;
  logic [31:0] out_wdata, byp_wdata;

  int n_cmp = 0;
  int n_mis = 0;

  wb_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stalled   (stalled),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wd     (in_wd),
    .in_wreg   (in_wreg),
    .in_wdata  (in_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wd    (out_wd),
    .out_wreg  (out_wreg),
    .out_wdata (out_wdata),
    .byp_wreg  (byp_wreg),
    .byp_wd    (byp_wd),
    .byp_wdata (byp_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity two with a ready flag computed from its fill.
  ent_t q[$];
  logic rdy_m = 1'b1;
  logic adv_m, acc_m;
  ent_t e_in;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      rdy_m = 1'b1;
    end else begin
      adv_m = (q.size() > 0) && out_ready && !stalled[4];
      acc_m = in_valid && rdy_m;
      if (flush) begin
        q.delete();
      end else begin
        if (adv_m) void'(q.pop_front());
        if (acc_m) begin
          e_in.wd   = in_wd;
          e_in.wreg = in_wreg && (in_wd != 5'd0);
          e_in.data = in_wdata;
          q.push_back(e_in);
        end
      end
      rdy_m = (q.size() < 2);
    end
  end

  logic log_en = 1'b0;
  logic [4:0] retired[$];

  always @(negedge clk) begin
    ent_t h;
    ent_t y;
    logic v;
    if (rst) begin
      v = (q.size() > 0);
      h = '0;
      y = '0;
      if (v) begin
        h = q[0];
        y = q[$];
      end
      chk("m_out_valid", out_valid, v);
      chk("m_in_ready", in_ready, rdy_m);
      chk("m_out_wd", out_wd, h.wd);
      chk("m_out_wreg", out_wreg, h.wreg);
      chk("m_out_wdata", out_wdata, h.data);
`ifdef WB_BYPASS_EN
      chk("m_byp_wreg", byp_wreg, y.wreg);
      chk("m_byp_wd", byp_wd, y.wd);
      chk("m_byp_wdata", byp_wdata, y.data);
`else
      chk("m_byp_wreg", byp_wreg, 1'b0);
      chk("m_byp_wd", byp_wd, 5'd0);
      chk("m_byp_wdata", byp_wdata, 32'd0);
`endif
      if (log_en && out_valid && out_ready && !stalled[4]) retired.push_back(out_wd);
    end
  end

  task automatic drive(input logic v, input logic [4:0] wd, input logic wr, input logic [31:0] d);
    in_valid = v;
    in_wd    = wd;
    in_wreg  = wr;
    in_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int nxt;
    int guard;

    // Reset values
    repeat (2) step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_wd", out_wd, 5'd0);
    chk("rst_out_wreg", out_wreg, 1'b0);
    chk("rst_out_wdata", out_wdata, 32'd0);
    chk("rst_byp_wreg", byp_wreg, 1'b0);
    rst = 1'b1;
    step();

    // Streaming, 1-cycle latency, no gaps
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 1'b1, 32'(i * 16));
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_wd", out_wd, 64'(i));
      chk("stream_wdata", out_wdata, 64'(i * 16));
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    step();
    chk("stream_drained", out_valid, 1'b0);

    // Backpressure: two accepts then in_ready drops
    out_ready = 1'b0;
    acc = 0;
    nxt = 9;
    retired.delete();
    log_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'(nxt), 1'b1, 32'(nxt * 16));
      if (in_ready) begin
        acc++;
        nxt++;
      end
      step();
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head_wd", out_wd, 5'd9);
    out_ready = 1'b1;
    guard = 0;
    while (nxt <= 14 && guard < 20) begin
      drive(1'b1, 5'(nxt), 1'b1, 32'(nxt * 16));
      if (in_ready) nxt++;
      step();
      guard++;
    end
    chk("bp_send_bound", 64'(guard < 20), 64'd1);
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    repeat (3) step();
    log_en = 1'b0;
    chk("bp_retired_count", 64'(retired.size()), 64'd6);
    for (int k = 0; k < retired.size() && k < 6; k++) chk("bp_order", retired[k], 64'(9 + k));

    // Stall freezes the output; release retires it exactly once
    drive(1'b1, 5'd3, 1'b1, 32'h33);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    retired.delete();
    log_en = 1'b1;
    stalled = 5'b10000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_wd", out_wd, 5'd3);
      chk("stall_wdata", out_wdata, 32'h33);
    end
    stalled = 5'b00000;
    step();
    log_en = 1'b0;
    chk("stall_released", out_valid, 1'b0);
    chk("stall_retire_once", 64'(retired.size()), 64'd1);

    // Flush in TWO drops everything including the concurrent input
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'h11);
    step();
    drive(1'b1, 5'd2, 1'b1, 32'h22);
    step();
    chk("flush_pre_ready", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 5'd4, 1'b1, 32'h44);
    step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_wd", out_wd, 5'd0);
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    step();
    chk("flush_dropped", out_valid, 1'b0);

    // x0 suppression and bypass from the skid entry
    drive(1'b1, 5'd0, 1'b1, 32'hDEAD);
    step();
    chk("x0_valid", out_valid, 1'b1);
    chk("x0_wreg", out_wreg, 1'b0);
    chk("x0_wdata", out_wdata, 32'hDEAD);
    drive(1'b1, 5'd7, 1'b1, 32'h77);
    step();
`ifdef WB_BYPASS_EN
    chk("byp_wd_skid", byp_wd, 5'd7);
    chk("byp_wdata_skid", byp_wdata, 32'h77);
    chk("byp_wreg_skid", byp_wreg, 1'b1);
`else
    chk("byp_wd_off", byp_wd, 5'd0);
    chk("byp_wreg_off", byp_wreg, 1'b0);
`endif
    chk("x0_head_kept", out_wdata, 32'hDEAD);
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    repeat (3) step();

    // Async reset mid-run with two entries held
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'h55);
    step();
    drive(1'b1, 5'd6, 1'b1, 32'h66);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    chk("arst_pre_valid", out_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_wreg", out_wreg, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_byp_wreg", byp_wreg, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("arst_after", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
